adder_share_ctrl: RTL and testbench

//  Shares one ripple_carry_16_bit adder (instantiated internally) between NREQ requesters.

---
 rtl/adder_share_pkg.sv | 33 +++
 rtl/adder_share_ctrl_rr_arbiter.sv | 26 ++
 rtl/ripple_carry_16_bit.sv | 21 ++
 rtl/adder_share_ctrl.sv | 139 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared constants, FSM encodings and the round-robin pick helper for adder_share_ctrl.
package adder_share_pkg;

    localparam int DW     = 16;
    localparam int MAXREQ = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of valid scanning ptr, ptr+1, ... modulo nreq.
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                      input logic [2:0]        ptr,
                                      input int unsigned       nreq);
        pick_t p;
        p = '0;
        for (int unsigned k = 0; k < nreq; k++) begin
            int unsigned i;
            i = (32'(ptr) + k) % nreq;
            if (!p.found && valid[i[2:0]]) begin
                p.found = 1'b1;
                p.idx   = i[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index, gated by en.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(MAXREQ'(req), 3'(ptr), NREQ);
        gnt     = '0;
        gnt_idx = IDW'(pick.idx);
        if (en && pick.found) begin
            gnt = NREQ'(1) << pick.idx;
        end
    end

endmodule

// File: rtl/ripple_carry_16_bit.sv
// 16-bit carry-ripple adder; purely combinational, no handshake.
module ripple_carry_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[16];

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one ripple-carry adder between NREQ requesters with round-robin grant,
// a fixed SETTLE-cycle hold on the adder inputs and a tagged single-entry response.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 3,
    parameter int IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic            cout_q, cout_d;
    logic [15:0]     opc_q, opc_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [DW-1:0]   add_sum;
    logic            add_cout;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == ST_IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Adder sees only registered operands, so requester churn cannot disturb a settling op.
    ripple_carry_16_bit u_add (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        opc_d   = opc_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    a_d     = req_a[DW*int'(gnt_idx) +: DW];
                    b_d     = req_b[DW*int'(gnt_idx) +: DW];
                    cin_d   = req_cin[gnt_idx];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    sum_d   = add_sum;
                    cout_d  = add_cout;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    opc_d   = opc_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            opc_q   <= opc_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign op_count  = opc_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_adder_share_ctrl;

    localparam int NREQ   = 4;
    localparam int SETTLE = 3;
    localparam int IDW    = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 busy;
    logic [15:0]          op_count;

    adder_share_ctrl #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int a;
        int b;
        int cin;
    } op_t;

    int  n_vec = 0;
    int  n_err = 0;

    // Reference model: an op is outstanding from grant until its response handshake.
    bit  m_busy, m_resp;
    int  m_left, m_ptr, m_count;
    op_t pend[$];

    int  cyc = 0, t_acc = 0, rv_rises = 0, hs_count = 0;
    bit  prev_rv = 1'b0;
    int  last_id, last_sum, last_cout;
    int  glog[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_resp  = 1'b0;
        m_left  = 0;
        m_ptr   = 0;
        m_count = 0;
        pend.delete();
    endtask

    task automatic step();
        int              g;
        int              s;
        op_t             o;
        logic [NREQ-1:0] er;
        @(negedge clk);
        cyc++;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(er));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_resp));
        check_eq("op_count", 32'(op_count), m_count & 32'hFFFF);
        if (m_resp && pend.size() > 0) begin
            o = pend[0];
            s = o.a + o.b + o.cin;
            check_eq("rsp_id", 32'(rsp_id), o.id);
            check_eq("rsp_sum", 32'(rsp_sum), s & 32'hFFFF);
            check_eq("rsp_cout", 32'(rsp_cout), (s >> 16) & 1);
        end
        for (int k = 0; k < NREQ; k++) if (req_ready[k] === 1'b1) glog.push_back(k);
        if (rsp_valid === 1'b1 && !prev_rv) begin
            rv_rises++;
            check_eq("latency", cyc - t_acc, SETTLE + 1);
        end
        prev_rv = (rsp_valid === 1'b1);
        if (rsp_valid === 1'b1 && rsp_ready && !rst) begin
            hs_count++;
            last_id   = int'(rsp_id);
            last_sum  = int'(rsp_sum);
            last_cout = int'(rsp_cout);
        end
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (g >= 0) begin
                o.id  = g;
                o.a   = int'(req_a[16*g +: 16]);
                o.b   = int'(req_b[16*g +: 16]);
                o.cin = int'(req_cin[g]);
                pend.push_back(o);
                m_ptr  = (g + 1) % NREQ;
                m_busy = 1'b1;
                m_left = SETTLE;
                t_acc  = cyc;
            end
        end else if (!m_resp) begin
            m_left--;
            if (m_left == 0) m_resp = 1'b1;
        end else if (rsp_ready) begin
            m_resp  = 1'b0;
            m_busy  = 1'b0;
            m_count = m_count + 1;
            void'(pend.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_cin[id]        = cin;
    endtask

    task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b, input logic cin);
        int start;
        set_req(id, a, b, cin);
        rsp_ready     = 1'b1;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        step();
        req_valid = '0;
        start = hs_count;
        for (int n = 0; n < 20 && hs_count == start; n++) step();
        check_eq("rsp_timeout", 32'(hs_count > start), 1);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && m_busy; n++) step();
        check_eq("drain_idle", 32'(m_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_id", 32'(rsp_id), 0);
        check_eq("rst_rsp_sum", 32'(rsp_sum), 0);
        check_eq("rst_rsp_cout", 32'(rsp_cout), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_op_count", 32'(op_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_single(0, 16'h001F, 16'h000C, 1'b0);
        check_eq("t1_id", last_id, 0);
        check_eq("t1_sum", last_sum, 32'h002B);
        check_eq("t1_cout", last_cout, 0);
        run_single(2, 16'hC61F, 16'h018C, 1'b1);
        check_eq("t2_id", last_id, 2);
        check_eq("t2_sum", last_sum, 32'hC7AC);
        check_eq("t2_cout", last_cout, 0);
        run_single(1, 16'hFFFF, 16'h0000, 1'b1);
        check_eq("t3_id", last_id, 1);
        check_eq("t3_sum", last_sum, 0);
        check_eq("t3_cout", last_cout, 1);
        check_eq("t3_op_count", 32'(op_count), 3);

        // All four requesting from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1'(i));
        req_valid = '1;
        glog.delete();
        for (int n = 0; n < 60 && glog.size() < 5; n++) step();
        check_eq("order_count", glog.size(), 5);
        for (int i = 0; i < 5; i++) check_eq("order", (glog.size() > i) ? glog[i] : 99, i % NREQ);
        drain();

        // Response stalled for five cycles while everyone else is requesting.
        set_req(3, 16'h8000, 16'h8001, 1'b1);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        step();
        req_valid = '1;
        for (int n = 0; n < 20 && rsp_valid !== 1'b1; n++) step();
        check_eq("stall_reached", 32'(rsp_valid), 1);
        r0 = hs_count;
        repeat (4) step();
        check_eq("stall_no_hs", hs_count, r0);
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        check_eq("stall_hs", hs_count, r0 + 1);
        check_eq("stall_sum", last_sum, 32'h0002);
        check_eq("stall_cout", last_cout, 1);
        check_eq("stall_id", last_id, 3);
        drain();

        // Reset while the adder is settling.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        r0  = rv_rises;
        step();
        rst = 1'b0;
        step();
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_no_rsp", rv_rises, r0);
        req_valid = '1;
        glog.delete();
        step();
        check_eq("abort_regrant", (glog.size() > 0) ? glog[0] : 99, 0);
        drain();

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = NREQ'($urandom & $urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 5))
                    0:       set_req(i, 16'hFFFF, 16'($urandom), 1'($urandom));
                    1:       set_req(i, 16'h0000, 16'h0000, 1'($urandom));
                    default: set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
                endcase
            end
            step();
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
